// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory-access stage.
//   state_t     : access FSM states (IDLE, WAIT)
//   BE_*        : byte-enable patterns, bit 3 = data bits 31:24 (big-endian lanes)
//   cnt_width() : width of the WAIT-cycle counter for a given timeout
package mem_stage_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  localparam logic [3:0] BE_WORD = 4'b1111;
  localparam logic [3:0] BE_B0   = 4'b1000;  // address offset 00 -> bits 31:24
  localparam logic [3:0] BE_B1   = 4'b0100;  // address offset 01 -> bits 23:16
  localparam logic [3:0] BE_B2   = 4'b0010;  // address offset 10 -> bits 15:8
  localparam logic [3:0] BE_B3   = 4'b0001;  // address offset 11 -> bits 7:0

  // The counter only has to reach timeout-1; keep it at least one bit wide.
  function automatic int cnt_width(input int timeout);
    return (timeout <= 2) ? 1 : $clog2(timeout);
  endfunction

endpackage

// File: rtl/mem_byte_lane.sv
// Combinational lane steering for the memory stage.
//   byte_mode  : 1 = byte access (lb/sb), 0 = word access
//   offset     : address bits [1:0]
//   store_data : register data to store
//   load_data  : raw word returned by memory
//   wdata      : store data presented to memory (byte replicated on all lanes)
//   be         : byte enables, bit 3 = bits 31:24
//   read_data  : load result, byte lane sign-extended to 32 bits
module mem_byte_lane
  import mem_stage_pkg::*;
(
  input  logic        byte_mode,
  input  logic [1:0]  offset,
  input  logic [31:0] store_data,
  input  logic [31:0] load_data,
  output logic [31:0] wdata,
  output logic [3:0]  be,
  output logic [31:0] read_data
);

  logic [7:0] lane;
  logic [3:0] byte_be;

  // Big-endian: offset 0 is the most significant byte of the word.
  always_comb begin
    lane    = load_data[7:0];
    byte_be = BE_B3;
    case (offset)
      2'b00: begin lane = load_data[31:24]; byte_be = BE_B0; end
      2'b01: begin lane = load_data[23:16]; byte_be = BE_B1; end
      2'b10: begin lane = load_data[15:8];  byte_be = BE_B2; end
      default: begin lane = load_data[7:0]; byte_be = BE_B3; end
    endcase
  end

  always_comb begin
    wdata     = store_data;
    be        = BE_WORD;
    read_data = load_data;
    if (byte_mode) begin
      wdata     = {4{store_data[7:0]}};
      be        = byte_be;
      read_data = {{24{lane[7]}}, lane};
    end
  end

endmodule

// File: rtl/mem_access_stage.sv
// Memory stage: issues data-memory loads/stores from the EXE/MEM register,
// stalls the front of the pipeline while memory is busy, and registers the
// outcome into the MEM/WB boundary.
//   EXE_MEM_*   : instruction fields from the EXE/MEM register (held while stalled)
//   dmem_*      : data-memory request/response port
//   MEM_Stall   : freeze PC/IF/ID/EXE/EXE_MEM this cycle
//   MEM_WB_*    : registered results for write-back
//   MEM_Misalign, MEM_BusErr : one-cycle fault pulses aligned with MEM/WB
//   fsm_state, wait_count    : debug view of the access FSM and WAIT counter
//
// Handshake: dmem_req is a valid that, once raised, stays high with
// we/addr/wdata/be unchanged until a cycle with dmem_ack=1 completes the
// access (ack may coincide with the first req cycle). dmem_ack in a cycle
// without dmem_req is ignored. A timeout drops the request without an ack.
module mem_access_stage
  import mem_stage_pkg::*;
#(
  parameter  int TIMEOUT = 255,
  localparam int CNT_W   = cnt_width(TIMEOUT)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      EXE_MEM_Result,
  input  logic [31:0]      EXE_MEM_Rt,
  input  logic [4:0]       EXE_MEM_DstReg,
  input  logic             EXE_MEM_MemRead,
  input  logic             EXE_MEM_MemWrite,
  input  logic             EXE_MEM_MemtoReg,
  input  logic             EXE_MEM_RegWrite,
  input  logic             EXE_MEM_Byte,
  input  logic             EXE_MEM_JmpandLink,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic [31:0]      dmem_addr,
  output logic [31:0]      dmem_wdata,
  output logic [3:0]       dmem_be,
  input  logic [31:0]      dmem_rdata,
  input  logic             dmem_ack,
  output logic             MEM_Stall,
  output logic [31:0]      MEM_WB_Result,
  output logic [31:0]      MEM_WB_ReadData,
  output logic [4:0]       MEM_WB_DstReg,
  output logic             MEM_WB_MemtoReg,
  output logic             MEM_WB_RegWrite,
  output logic             MEM_WB_JmpandLink,
  output logic             MEM_Misalign,
  output logic             MEM_BusErr,
  output logic             fsm_state,
  output logic [CNT_W-1:0] wait_count
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t           state;
  logic [CNT_W-1:0] count;
  logic             acc;
  logic             misal;
  logic             abort;
  logic [31:0]      load_data;

  assign acc   = EXE_MEM_MemRead | EXE_MEM_MemWrite;
  assign misal = acc & ~EXE_MEM_Byte & (EXE_MEM_Result[1:0] != 2'b00);

  // Inputs are frozen while stalled, so driving the request straight from
  // EXE/MEM keeps it stable until ack without extra holding registers.
  assign dmem_req  = (state == WAIT) | (acc & ~misal);
  assign dmem_we   = EXE_MEM_MemWrite;
  assign dmem_addr = {EXE_MEM_Result[31:2], 2'b00};

  // The last WAIT cycle without ack aborts and releases the stall in the
  // same cycle, so the stall spans exactly TIMEOUT cycles.
  assign abort     = (state == WAIT) & ~dmem_ack & (count == CNT_LAST);
  assign MEM_Stall = dmem_req & ~dmem_ack & ~abort;

  assign fsm_state  = state;
  assign wait_count = count;

  mem_byte_lane u_lane (
    .byte_mode  (EXE_MEM_Byte),
    .offset     (EXE_MEM_Result[1:0]),
    .store_data (EXE_MEM_Rt),
    .load_data  (dmem_rdata),
    .wdata      (dmem_wdata),
    .be         (dmem_be),
    .read_data  (load_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= IDLE;
      count             <= '0;
      MEM_WB_Result     <= '0;
      MEM_WB_ReadData   <= '0;
      MEM_WB_DstReg     <= '0;
      MEM_WB_MemtoReg   <= 1'b0;
      MEM_WB_RegWrite   <= 1'b0;
      MEM_WB_JmpandLink <= 1'b0;
      MEM_Misalign      <= 1'b0;
      MEM_BusErr        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (dmem_req && !dmem_ack) begin
            state <= WAIT;
            count <= '0;
          end
        end
        WAIT: begin
          if (dmem_ack || abort) begin
            state <= IDLE;
            count <= '0;
          end else begin
            count <= count + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          count <= '0;
        end
      endcase

      // A misaligned access never raises a request, so it never stalls.
      MEM_Misalign <= misal;
      MEM_BusErr   <= abort;

      if (MEM_Stall) begin
        // Bubble: kill the control bits, leave data fields as they were.
        MEM_WB_MemtoReg   <= 1'b0;
        MEM_WB_RegWrite   <= 1'b0;
        MEM_WB_JmpandLink <= 1'b0;
      end else begin
        MEM_WB_Result     <= EXE_MEM_Result;
        MEM_WB_ReadData   <= load_data;
        MEM_WB_DstReg     <= EXE_MEM_DstReg;
        MEM_WB_MemtoReg   <= EXE_MEM_MemtoReg;
        MEM_WB_JmpandLink <= EXE_MEM_JmpandLink;
        MEM_WB_RegWrite   <= EXE_MEM_RegWrite & ~misal & ~abort;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Testbench for mem_access_stage: directed instructions with hand-computed
// MEM/WB expectations pushed to a queue; a monitor pops and compares each
// retirement, and checks bubbles and reset values.
module tb_mem_access_stage;
  import mem_stage_pkg::*;

  localparam int TO = 4;
  localparam int W  = 75;  // {chk_rdata, Result, ReadData, DstReg, MemtoReg, RegWrite, JmpandLink, Misalign, BusErr}

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] EXE_MEM_Result = '0;
  logic [31:0] EXE_MEM_Rt = '0;
  logic [4:0]  EXE_MEM_DstReg = '0;
  logic        EXE_MEM_MemRead = 1'b0;
  logic        EXE_MEM_MemWrite = 1'b0;
  logic        EXE_MEM_MemtoReg = 1'b0;
  logic        EXE_MEM_RegWrite = 1'b0;
  logic        EXE_MEM_Byte = 1'b0;
  logic        EXE_MEM_JmpandLink = 1'b0;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_rdata = '0;
  logic        dmem_ack = 1'b0;
  logic        MEM_Stall;
  logic [31:0] MEM_WB_Result;
  logic [31:0] MEM_WB_ReadData;
  logic [4:0]  MEM_WB_DstReg;
  logic        MEM_WB_MemtoReg;
  logic        MEM_WB_RegWrite;
  logic        MEM_WB_JmpandLink;
  logic        MEM_Misalign;
  logic        MEM_BusErr;
  logic        fsm_state;
  logic [cnt_width(TO)-1:0] wait_count;

  int tests = 0;
  int fails = 0;
  logic mon_en = 1'b1;
  logic [W-1:0] exp_q[$];

  mem_access_stage #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .EXE_MEM_Result(EXE_MEM_Result), .EXE_MEM_Rt(EXE_MEM_Rt),
    .EXE_MEM_DstReg(EXE_MEM_DstReg), .EXE_MEM_MemRead(EXE_MEM_MemRead),
    .EXE_MEM_MemWrite(EXE_MEM_MemWrite), .EXE_MEM_MemtoReg(EXE_MEM_MemtoReg),
    .EXE_MEM_RegWrite(EXE_MEM_RegWrite), .EXE_MEM_Byte(EXE_MEM_Byte),
    .EXE_MEM_JmpandLink(EXE_MEM_JmpandLink),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_rdata(dmem_rdata),
    .dmem_ack(dmem_ack), .MEM_Stall(MEM_Stall),
    .MEM_WB_Result(MEM_WB_Result), .MEM_WB_ReadData(MEM_WB_ReadData),
    .MEM_WB_DstReg(MEM_WB_DstReg), .MEM_WB_MemtoReg(MEM_WB_MemtoReg),
    .MEM_WB_RegWrite(MEM_WB_RegWrite), .MEM_WB_JmpandLink(MEM_WB_JmpandLink),
    .MEM_Misalign(MEM_Misalign), .MEM_BusErr(MEM_BusErr),
    .fsm_state(fsm_state), .wait_count(wait_count)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Driver: presents one instruction, plays the memory (ack after ack_at
  // cycles, -1 = never), checks the request each cycle and the stall length,
  // then queues the expected MEM/WB contents.
  task automatic issue(
    input string name,
    input logic [31:0] result, input logic [31:0] rt, input logic [4:0] dst,
    input logic rd, input logic wr, input logic m2r, input logic rw,
    input logic byt, input logic jal,
    input int ack_at, input logic [31:0] rdata,
    input int exp_stall, input logic exp_req,
    input logic [3:0] exp_be, input logic [31:0] exp_wdata,
    input logic chk_rd, input logic [31:0] exp_rd,
    input logic exp_rw, input logic exp_mis, input logic exp_bus);
    int k;
    logic [31:0] exp_addr;
    exp_addr = {result[31:2], 2'b00};
    @(negedge clk);
    rst = 1'b0;
    EXE_MEM_Result = result; EXE_MEM_Rt = rt; EXE_MEM_DstReg = dst;
    EXE_MEM_MemRead = rd; EXE_MEM_MemWrite = wr; EXE_MEM_MemtoReg = m2r;
    EXE_MEM_RegWrite = rw; EXE_MEM_Byte = byt; EXE_MEM_JmpandLink = jal;
    k = 0;
    forever begin
      dmem_ack   = (k == ack_at);
      dmem_rdata = (k == ack_at) ? rdata : 32'h0;
      #1;
      check({name, "_req"}, W'(dmem_req), W'(exp_req));
      if (exp_req) begin
        check({name, "_addr"}, W'(dmem_addr), W'(exp_addr));
        check({name, "_we"}, W'(dmem_we), W'(wr));
        check({name, "_be"}, W'(dmem_be), W'(exp_be));
        check({name, "_wdata"}, W'(dmem_wdata), W'(exp_wdata));
      end else begin
        check({name, "_state"}, W'(fsm_state), W'(IDLE));
      end
      if (!MEM_Stall) break;
      k++;
      if (k > 40) begin
        tests++; fails++;
        $display("FAIL %s_stall_bound: stall still high after %0d cycles", name, k);
        break;
      end
      @(negedge clk);
    end
    check({name, "_stall_cycles"}, W'(k), W'(exp_stall));
    exp_q.push_back({chk_rd, result, exp_rd, dst, m2r, exp_rw, jal, exp_mis, exp_bus});
  endtask

  // Scoreboard monitor: MEM/WB seen at negedge reflects the previous cycle.
  initial begin : monitor
    logic have_prev;
    logic prev_stall;
    logic prev_rst;
    logic [W-1:0] e;
    logic [W-2:0] act;
    logic [W-2:0] mask;
    have_prev = 1'b0; prev_stall = 1'b0; prev_rst = 1'b1;
    forever begin
      @(negedge clk);
      #2;
      act = {MEM_WB_Result, MEM_WB_ReadData, MEM_WB_DstReg, MEM_WB_MemtoReg,
             MEM_WB_RegWrite, MEM_WB_JmpandLink, MEM_Misalign, MEM_BusErr};
      if (have_prev && mon_en) begin
        if (prev_rst) begin
          check("reset_memwb", W'(act), '0);
        end else if (prev_stall) begin
          check("bubble_ctrl", W'({MEM_WB_MemtoReg, MEM_WB_RegWrite, MEM_WB_JmpandLink,
                                   MEM_Misalign, MEM_BusErr}), '0);
        end else if (exp_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL sb_underflow: retirement 0x%0h with nothing expected", act);
        end else begin
          e = exp_q.pop_front();
          mask = e[W-1] ? '1 : ~((W-1)'(32'hFFFF_FFFF) << 10);
          check("memwb", W'(act & mask), W'(e[W-2:0] & mask));
        end
      end
      have_prev  = 1'b1;
      prev_stall = MEM_Stall;
      prev_rst   = rst;
    end
  end

  initial begin
    repeat (3) @(posedge clk);
    //     name      result        rt            dst   rd wr m2r rw byt jal ack rdata         stl req be       wdata         chk rd_exp        rw mis bus
    issue("lw0",     32'h100,      32'h0,        5'd5, 1, 0, 1,  1, 0,  0,  0, 32'hDEADBEEF, 0,  1,  4'b1111, 32'h0,        1,  32'hDEADBEEF, 1, 0,  0);
    issue("lb3",     32'h103,      32'h0,        5'd6, 1, 0, 1,  1, 1,  0,  3, 32'h000000F0, 3,  1,  4'b0001, 32'h0,        1,  32'hFFFFFFF0, 1, 0,  0);
    issue("sb1",     32'h201,      32'h12345678, 5'd0, 0, 1, 0,  0, 1,  0,  1, 32'h0,        1,  1,  4'b0100, 32'h78787878, 0,  32'h0,        0, 0,  0);
    issue("sw",      32'h300,      32'hAABBCCDD, 5'd0, 0, 1, 0,  0, 0,  0,  0, 32'h0,        0,  1,  4'b1111, 32'hAABBCCDD, 0,  32'h0,        0, 0,  0);
    issue("lb0",     32'h100,      32'h0,        5'd7, 1, 0, 1,  1, 1,  0,  1, 32'h7F000000, 1,  1,  4'b1000, 32'h0,        1,  32'h0000007F, 1, 0,  0);
    issue("lb2",     32'h102,      32'h0,        5'd8, 1, 0, 1,  1, 1,  0,  2, 32'h00008000, 2,  1,  4'b0010, 32'h0,        1,  32'hFFFFFF80, 1, 0,  0);
    issue("lw_mis",  32'h102,      32'h0,        5'd9, 1, 0, 1,  1, 0,  0, -1, 32'h0,        0,  0,  4'b1111, 32'h0,        0,  32'h0,        0, 1,  0);
    issue("alu_ack", 32'h12345678, 32'h0,       5'd10, 0, 0, 0,  1, 0,  0,  0, 32'h0,        0,  0,  4'b1111, 32'h0,        0,  32'h0,        1, 0,  0);
    issue("jal",     32'h404,      32'h0,       5'd31, 0, 0, 0,  1, 0,  1, -1, 32'h0,        0,  0,  4'b1111, 32'h0,        0,  32'h0,        1, 0,  0);
    issue("lw_to",   32'h500,      32'h0,       5'd11, 1, 0, 1,  1, 0,  0, -1, 32'h0,        4,  1,  4'b1111, 32'h0,        0,  32'h0,        0, 0,  1);
    issue("alu",     32'hCAFE,     32'h0,       5'd12, 0, 0, 0,  1, 0,  0, -1, 32'h0,        0,  0,  4'b1111, 32'h0,        0,  32'h0,        1, 0,  0);
    issue("sb3",     32'h203,      32'h000000A5, 5'd0, 0, 1, 0,  0, 1,  0,  0, 32'h0,        0,  1,  4'b0001, 32'hA5A5A5A5, 0,  32'h0,        0, 0,  0);
    issue("sw_mis",  32'h306,      32'h11223344, 5'd0, 0, 1, 0,  0, 0,  0, -1, 32'h0,        0,  0,  4'b1111, 32'h11223344, 0,  32'h0,        0, 1,  0);

    // Reset during the second WAIT cycle of an unanswered load.
    @(negedge clk);
    EXE_MEM_Result = 32'h600; EXE_MEM_Rt = 32'h0; EXE_MEM_DstReg = 5'd13;
    EXE_MEM_MemRead = 1'b1; EXE_MEM_MemWrite = 1'b0; EXE_MEM_MemtoReg = 1'b1;
    EXE_MEM_RegWrite = 1'b1; EXE_MEM_Byte = 1'b0; EXE_MEM_JmpandLink = 1'b0;
    dmem_ack = 1'b0; dmem_rdata = 32'h0;
    #1;
    check("rstw_stall", W'(MEM_Stall), W'(1'b1));
    @(negedge clk);
    #1;
    check("rstw_state_wait", W'(fsm_state), W'(WAIT));
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rstw_count", W'(wait_count), W'(1));
    issue("post_rst", 32'h0, 32'h0, 5'd0, 0, 0, 0, 0, 0, 0, -1, 32'h0, 0, 0, 4'b1111, 32'h0, 1, 32'h0, 0, 0, 0);
    check("post_rst_count", W'(wait_count), '0);
    issue("after",   32'h77,       32'h0,       5'd14, 0, 0, 0,  1, 0,  0, -1, 32'h0,        0,  0,  4'b1111, 32'h0,        0,  32'h0,        1, 0,  0);

    @(negedge clk);
    #3;
    mon_en = 1'b0;
    check("sb_drained", W'(exp_q.size()), '0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mem_access_stage.md
# mem_access_stage

Memory-stage access unit that consumes the EXE/MEM pipeline register outputs, performs the data-memory load/store over a req/ack handshake, stalls the front of the pipeline while memory is busy, and registers results into the MEM/WB boundary. Handles word and byte (lb/sb, big-endian lanes) accesses, misalignment detection and a memory-response timeout. It sits between the EXE/MEM register and the write-back stage.

## Interface
- TIMEOUT, 255: max cycles spent in WAIT before the access is aborted (1..65535).
- clk  in  1  pipeline clock; all state changes on posedge.
- rst  in  1  synchronous, active-high reset.
- EXE_MEM_Result  in  32  ALU result or effective address; link address when JmpandLink=1.
- EXE_MEM_Rt  in  32  store data.
- EXE_MEM_DstReg  in  5  destination register.
- EXE_MEM_MemRead, EXE_MEM_MemWrite  in  1 each  load/store request (mutually exclusive).
- EXE_MEM_MemtoReg, EXE_MEM_RegWrite, EXE_MEM_Byte, EXE_MEM_JmpandLink  in  1 each  control bits.
- dmem_req  out  1  memory request valid.
- dmem_we  out  1  1 = store.
- dmem_addr  out  32  word address, {EXE_MEM_Result[31:2],2'b00}.
- dmem_wdata  out  32  store data.
- dmem_be  out  4  byte enables, bit 3 = bits 31:24.
- dmem_rdata  in  32  load data, valid with dmem_ack.
- dmem_ack  in  1  access complete; may be high in the same cycle as first dmem_req.
- MEM_Stall  out  1  freeze PC/IF/ID/EXE/EXE_MEM this cycle.
- MEM_WB_Result, MEM_WB_ReadData  out  32 each  registered ALU result / aligned load data.
- MEM_WB_DstReg  out  5.
- MEM_WB_MemtoReg, MEM_WB_RegWrite, MEM_WB_JmpandLink  out  1 each.
- MEM_Misalign, MEM_BusErr  out  1 each  one-cycle registered fault pulses.

## Operation
- acc = MemRead|MemWrite; misal = acc & ~Byte & (Result[1:0]!=0).
- FSM states IDLE, WAIT. IDLE: dmem_req = acc & ~misal; if req & ~ack -> WAIT, counter cleared. WAIT: dmem_req=1; ack -> IDLE; counter==TIMEOUT-1 without ack -> IDLE, abort.
- MEM_Stall = dmem_req & ~dmem_ack & ~abort (combinational); upstream holds EXE_MEM inputs stable while high.
- Store word: wdata=Rt, be=4'b1111. Store byte: wdata={4{Rt[7:0]}}, be one-hot by Result[1:0]: 00->1000, 01->0100, 10->0010, 11->0001.
- Load word: ReadData=rdata. Load byte: lane selected as above, sign-extended to 32 bits.
- dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be held constant from first assertion until ack.
- MEM/WB capture on every posedge with MEM_Stall=0: Result, DstReg, MemtoReg, JmpandLink copied; RegWrite copied unless misal or abort (then 0).
- Cycles with MEM_Stall=1: MEM/WB loads a bubble (RegWrite=0, MemtoReg=0, JmpandLink=0; data fields hold).
- misal: no memory request, no stall, MEM_Misalign=1 next cycle, instruction retires with RegWrite=0.
- abort (timeout): MEM_BusErr=1 next cycle, RegWrite=0, stall released that cycle.
- Non-memory instructions pass through with one-cycle latency, no stall.

## Timing
- Reset: state IDLE, counter 0, every MEM_WB_* output 0, MEM_Misalign=MEM_BusErr=0. Reset mid-WAIT abandons the access; memory must tolerate a dropped request.
- Zero-wait memory (ack with first req): no stall, MEM/WB valid next edge.
- N-wait ack: MEM_Stall high N cycles, MEM/WB bubbles for N edges, then the real result.
- Timeout: stall lasts exactly TIMEOUT cycles.
- ack while IDLE with dmem_req=0 is ignored.

## Structure
- Package mem_stage_pkg: state enum {IDLE, WAIT}, byte-enable constants BE_WORD, BE_B0..BE_B3, counter width derivation.
- Sub-module mem_byte_lane: combinational store replication/byte-enable generation and load lane extract plus sign extension; the FSM, counter and MEM/WB registers remain in the top.

## Test plan
- Reset then lw Result=0x100, ack same cycle, rdata=0xDEADBEEF -> no stall, next edge MEM_WB_ReadData=0xDEADBEEF, RegWrite=1.
- lb Result=0x103, ack after 3 cycles, rdata=0x000000F0 -> MEM_Stall 3 cycles, 3 bubbles, ReadData=0xFFFFFFF0.
- sb Result=0x201, Rt=0x12345678 -> dmem_be=0100, wdata=0x78787878, we=1, addr=0x200.
- lw Result=0x102 -> no dmem_req, MEM_Misalign pulse, MEM_WB_RegWrite=0.
- TIMEOUT=4, lw with no ack -> stall exactly 4 cycles, MEM_BusErr pulse, RegWrite=0, next instruction proceeds.
- rst asserted in WAIT cycle 2 -> next cycle all MEM_WB_* =0, state IDLE, counter 0.
